// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant held per CYC
// and a stalled-strobe watchdog that answers ERR when the slave never responds.
module wb_rr_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_m0_cyc,
    input  logic                    i_m0_stb,
    input  logic                    i_m0_we,
    input  logic [ADDR_WIDTH-1:0]   i_m0_adr,
    input  logic [DATA_WIDTH-1:0]   i_m0_dat,
    input  logic [DATA_WIDTH/8-1:0] i_m0_sel,
    output logic [DATA_WIDTH-1:0]   o_m0_dat,
    output logic                    o_m0_ack,
    output logic                    o_m0_err,
    input  logic                    i_m1_cyc,
    input  logic                    i_m1_stb,
    input  logic                    i_m1_we,
    input  logic [ADDR_WIDTH-1:0]   i_m1_adr,
    input  logic [DATA_WIDTH-1:0]   i_m1_dat,
    input  logic [DATA_WIDTH/8-1:0] i_m1_sel,
    output logic [DATA_WIDTH-1:0]   o_m1_dat,
    output logic                    o_m1_ack,
    output logic                    o_m1_err,
    output logic                    o_s_cyc,
    output logic                    o_s_stb,
    output logic                    o_s_we,
    output logic [ADDR_WIDTH-1:0]   o_s_adr,
    output logic [DATA_WIDTH-1:0]   o_s_dat,
    output logic [DATA_WIDTH/8-1:0] o_s_sel,
    input  logic [DATA_WIDTH-1:0]   i_s_dat,
    input  logic                    i_s_ack,
    input  logic                    i_s_err,
    output logic [1:0]              o_grant
);

    // Handshake: a master owns the slave from grant until it drops cyc; each cycle with
    // owner stb high is one request, completed by ack or err in that same cycle.
    localparam bit             WD_EN    = (TIMEOUT > 0);
    localparam int             CW       = WD_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = WD_EN ? CW'(TIMEOUT - 1) : '0;

    // Encoding doubles as the one-hot owner vector seen on o_grant.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OWN0 = 2'b01,
        S_OWN1 = 2'b10
    } state_t;

    state_t        state, state_next;
    logic          last_m1, last_m1_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          abort, abort_next;
    logic          owned;
    logic          owner_cyc, owner_stb;
    logic          timeout_pulse;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            last_m1 <= 1'b1;
            cnt     <= '0;
            abort   <= 1'b0;
        end else begin
            state   <= state_next;
            last_m1 <= last_m1_next;
            cnt     <= cnt_next;
            abort   <= abort_next;
        end
    end

    always_comb begin
        state_next   = state;
        last_m1_next = last_m1;
        case (state)
            S_IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last_m1)) begin
                    state_next   = S_OWN0;
                    last_m1_next = 1'b0;
                end else if (i_m1_cyc) begin
                    state_next   = S_OWN1;
                    last_m1_next = 1'b1;
                end
            end
            S_OWN0: begin
                if (!i_m0_cyc) begin
                    if (i_m1_cyc) begin
                        state_next   = S_OWN1;
                        last_m1_next = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_OWN1: begin
                if (!i_m1_cyc) begin
                    if (i_m0_cyc) begin
                        state_next   = S_OWN0;
                        last_m1_next = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        owned     = (state == S_OWN0) || (state == S_OWN1);
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        if (state == S_OWN0) begin
            owner_cyc = i_m0_cyc;
            owner_stb = i_m0_stb;
        end else if (state == S_OWN1) begin
            owner_cyc = i_m1_cyc;
            owner_stb = i_m1_stb;
        end
    end

    // A coincident ack/err suppresses the timeout, so the slave's answer always wins.
    always_comb begin
        timeout_pulse = WD_EN && owned && owner_cyc && owner_stb && !abort &&
                        !i_s_ack && !i_s_err && (cnt == CNT_LAST);

        cnt_next = cnt + CW'(1);
        if (!WD_EN || !owned || abort || timeout_pulse || (state_next != state) ||
            !(owner_cyc && owner_stb) || i_s_ack || i_s_err) begin
            cnt_next = '0;
        end

        abort_next = abort;
        if (state_next != state) begin
            abort_next = 1'b0;
        end else if (timeout_pulse) begin
            abort_next = 1'b1;
        end
    end

    always_comb begin
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_adr  = '0;
        o_s_dat  = '0;
        o_s_sel  = '0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        case (state)
            S_OWN0: begin
                o_s_cyc  = i_m0_cyc & ~abort;
                o_s_stb  = i_m0_stb & ~abort;
                o_s_we   = i_m0_we;
                o_s_adr  = i_m0_adr;
                o_s_dat  = i_m0_dat;
                o_s_sel  = i_m0_sel;
                o_m0_ack = i_s_ack & ~abort;
                o_m0_err = (i_s_err & ~abort) | timeout_pulse;
            end
            S_OWN1: begin
                o_s_cyc  = i_m1_cyc & ~abort;
                o_s_stb  = i_m1_stb & ~abort;
                o_s_we   = i_m1_we;
                o_s_adr  = i_m1_adr;
                o_s_dat  = i_m1_dat;
                o_s_sel  = i_m1_sel;
                o_m1_ack = i_s_ack & ~abort;
                o_m1_err = (i_s_err & ~abort) | timeout_pulse;
            end
            default: ;
        endcase
    end

    assign o_m0_dat = i_s_dat;
    assign o_m1_dat = i_s_dat;
    assign o_grant  = state;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: grant latency, round-robin ties, bursts,
// watchdog timeout/abort, ack-vs-timeout priority, slave error and async reset.
module tb_wb_rr_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_m0_cyc, i_m0_stb, i_m0_we;
    logic [AW-1:0] i_m0_adr;
    logic [DW-1:0] i_m0_dat;
    logic [SW-1:0] i_m0_sel;
    logic [DW-1:0] o_m0_dat;
    logic          o_m0_ack, o_m0_err;
    logic          i_m1_cyc, i_m1_stb, i_m1_we;
    logic [AW-1:0] i_m1_adr;
    logic [DW-1:0] i_m1_dat;
    logic [SW-1:0] i_m1_sel;
    logic [DW-1:0] o_m1_dat;
    logic          o_m1_ack, o_m1_err;
    logic          o_s_cyc, o_s_stb, o_s_we;
    logic [AW-1:0] o_s_adr;
    logic [DW-1:0] o_s_dat;
    logic [SW-1:0] o_s_sel;
    logic [DW-1:0] i_s_dat;
    logic          i_s_ack, i_s_err;
    logic [1:0]    o_grant;

    int n_checks = 0;
    int n_errors = 0;

    wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
        .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel),
        .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
        .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel),
        .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
        .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_err(i_s_err),
        .o_grant(o_grant)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic m0_req(input logic on, input logic [AW-1:0] adr);
        i_m0_cyc = on;
        i_m0_stb = on;
        i_m0_adr = adr;
    endtask

    task automatic m1_req(input logic on, input logic [AW-1:0] adr);
        i_m1_cyc = on;
        i_m1_stb = on;
        i_m1_adr = adr;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_adr = '0; i_m0_dat = '0; i_m0_sel = '0;
        i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_adr = '0; i_m1_dat = '0; i_m1_sel = '0;
        i_s_dat = '0; i_s_ack = 0; i_s_err = 0;

        // Reset state
        #12;
        check("rst_grant", o_grant, 2'b00);
        check("rst_s_cyc", o_s_cyc, 0);
        check("rst_s_adr", o_s_adr, 0);
        i_reset_n = 1'b1;
        step();

        // Single m0 read, ack two cycles after stb
        m0_req(1, 30'h100);
        i_m0_sel = 4'hF;
        settle();
        check("t1_latency_cyc", o_s_cyc, 0);
        step();
        check("t1_s_cyc", o_s_cyc, 1);
        check("t1_grant", o_grant, 2'b01);
        check("t1_s_adr", o_s_adr, 30'h100);
        step();
        check("t1_no_early_ack", o_m0_ack, 0);
        step();
        i_s_ack = 1; i_s_dat = 32'hDEADBEEF;
        settle();
        check("t1_m0_ack", o_m0_ack, 1);
        check("t1_m0_dat", o_m0_dat, 32'hDEADBEEF);
        check("t1_m1_ack", o_m1_ack, 0);
        step();
        i_s_ack = 0;
        m0_req(0, '0);
        step();
        check("t1_idle", o_grant, 2'b00);

        // Tie from reset: m0 first, then m1 back-to-back
        i_reset_n = 1'b0;
        #2;
        i_reset_n = 1'b1;
        m0_req(1, 30'h10);
        m1_req(1, 30'h20);
        settle();
        check("t2_latency", o_grant, 2'b00);
        step();
        check("t2_tie1_grant", o_grant, 2'b01);
        check("t2_tie1_adr", o_s_adr, 30'h10);
        i_s_ack = 1;
        settle();
        check("t2_m0_ack", o_m0_ack, 1);
        check("t2_m1_no_ack", o_m1_ack, 0);
        step();
        i_s_ack = 0;
        m0_req(0, '0);
        settle();
        check("t2_hold_grant", o_grant, 2'b01);
        step();
        check("t2_b2b_grant", o_grant, 2'b10);
        check("t2_b2b_adr", o_s_adr, 30'h20);
        check("t2_b2b_cyc", o_s_cyc, 1);
        m1_req(0, '0);
        step();
        check("t2_idle", o_grant, 2'b00);
        m0_req(1, 30'h11);
        m1_req(1, 30'h21);
        step();
        check("t2_tie2_grant", o_grant, 2'b01);
        m0_req(0, '0);
        m1_req(0, '0);
        step();
        m0_req(1, 30'h12);
        m1_req(1, 30'h22);
        step();
        check("t2_tie3_grant", o_grant, 2'b10);
        m0_req(0, '0);
        m1_req(0, '0);
        step();

        // m1 four-beat burst while m0 waits
        m1_req(1, 30'h200);
        i_m1_sel = 4'h3; i_m1_we = 1; i_m1_dat = 32'h5555AAAA;
        step();
        m0_req(1, 30'h300);
        for (int i = 0; i < 4; i++) begin
            i_m1_adr = 30'h200 + AW'(i);
            i_s_ack = 1;
            settle();
            check("t3_s_adr", o_s_adr, 30'h200 + i);
            check("t3_s_sel", o_s_sel, 4'h3);
            check("t3_s_dat", o_s_dat, 32'h5555AAAA);
            check("t3_m1_ack", o_m1_ack, 1);
            check("t3_m0_ack", o_m0_ack, 0);
            check("t3_grant", o_grant, 2'b10);
            step();
        end
        i_s_ack = 0;
        m1_req(0, '0);
        i_m1_we = 0;
        settle();
        check("t3_m0_still_waits", o_m0_ack, 0);
        step();
        check("t3_m0_grant", o_grant, 2'b01);
        check("t3_m0_adr", o_s_adr, 30'h300);
        m0_req(0, '0);
        step();

        // Watchdog: m0 stalls, err in stall cycle 8, abort until m0 drops cyc
        m0_req(1, 30'h40);
        step();
        for (int k = 1; k <= 8; k++) begin
            settle();
            check("t4_err", o_m0_err, (k == 8) ? 1 : 0);
            check("t4_s_cyc", o_s_cyc, 1);
            step();
        end
        settle();
        check("t4_abort_cyc", o_s_cyc, 0);
        check("t4_abort_stb", o_s_stb, 0);
        check("t4_err_once", o_m0_err, 0);
        check("t4_abort_grant", o_grant, 2'b01);
        m1_req(1, 30'h77);
        i_s_ack = 1;
        settle();
        check("t4_abort_ack_m0", o_m0_ack, 0);
        check("t4_abort_ack_m1", o_m1_ack, 0);
        check("t4_abort_cyc2", o_s_cyc, 0);
        i_s_ack = 0;
        m0_req(0, '0);
        step();
        check("t4_m1_grant", o_grant, 2'b10);
        check("t4_m1_cyc", o_s_cyc, 1);
        check("t4_m1_adr", o_s_adr, 30'h77);
        i_s_ack = 1;
        settle();
        check("t4_m1_ack", o_m1_ack, 1);
        step();
        i_s_ack = 0;
        m1_req(0, '0);
        step();

        // Ack coinciding with the timeout cycle, then a slave error
        m0_req(1, 30'h50);
        step();
        for (int k = 1; k <= 7; k++) begin
            settle();
            check("t5_err_pre", o_m0_err, 0);
            step();
        end
        i_s_ack = 1;
        settle();
        check("t5_ack_wins", o_m0_ack, 1);
        check("t5_no_err", o_m0_err, 0);
        step();
        i_s_ack = 0;
        settle();
        check("t5_cnt_cleared_err", o_m0_err, 0);
        check("t5_no_abort", o_s_cyc, 1);
        i_s_err = 1;
        settle();
        check("t5_serr_m0", o_m0_err, 1);
        check("t5_serr_m1", o_m1_err, 0);
        check("t5_serr_noack", o_m0_ack, 0);
        step();
        i_s_err = 0;
        m0_req(0, '0);
        step();

        // Asynchronous reset while m1 owns the slave
        m1_req(1, 30'h90);
        step();
        settle();
        check("t6_own1_cyc", o_s_cyc, 1);
        i_s_ack = 1;
        i_reset_n = 1'b0;
        settle();
        check("t6_rst_cyc", o_s_cyc, 0);
        check("t6_rst_stb", o_s_stb, 0);
        check("t6_rst_grant", o_grant, 2'b00);
        check("t6_rst_ack", o_m1_ack, 0);
        i_s_ack = 0;
        i_reset_n = 1'b1;
        m0_req(1, 30'h91);
        settle();
        check("t6_post_idle", o_grant, 2'b00);
        step();
        check("t6_tie_m0", o_grant, 2'b01);

        // Final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Lets the CPU instruction bus (m0) and data bus (m1) share a single slave port, e.g. a combined code/data RAM, or a peripheral reachable from both buses.
- Round-robin grant, held for a whole CYC; a bus-timeout watchdog returns ERR if the slave never acknowledges.
- Sits between VexRiscv bus outputs and the generated interconnect slave port.

Parameters:
- ADDR_WIDTH, 30, word-address width (byte address bits [31:2]).
- DATA_WIDTH, 32, data width; SEL width = DATA_WIDTH/8.
- TIMEOUT, 255, stalled-strobe cycles before abort; 0 disables the watchdog; counter width = clog2(TIMEOUT+1).

Ports:
- i_clk  in  1  bus clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_m0_cyc, i_m1_cyc  in  1 each  master cycle request.
- i_m0_stb, i_m1_stb  in  1 each  master strobe.
- i_m0_we, i_m1_we  in  1 each  write enable.
- i_m0_adr, i_m1_adr  in  ADDR_WIDTH each  word address.
- i_m0_dat, i_m1_dat  in  DATA_WIDTH each  write data.
- i_m0_sel, i_m1_sel  in  DATA_WIDTH/8 each  byte selects.
- o_m0_dat, o_m1_dat  out  DATA_WIDTH each  read data; both driven from i_s_dat.
- o_m0_ack, o_m1_ack  out  1 each  acknowledge.
- o_m0_err, o_m1_err  out  1 each  error (slave error or timeout).
- o_s_cyc, o_s_stb, o_s_we  out  1 each  slave control.
- o_s_adr  out  ADDR_WIDTH  slave address.
- o_s_dat  out  DATA_WIDTH  slave write data.
- o_s_sel  out  DATA_WIDTH/8  slave byte selects.
- i_s_dat  in  DATA_WIDTH  slave read data.
- i_s_ack, i_s_err  in  1 each  slave ack / error.
- o_grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 when idle.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - state = IDLE, last = m1 (so m0 wins the first tie), timeout counter = 0, abort flag = 0.
  - o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat, o_s_sel = 0; all o_mN_ack/err = 0; o_grant = 00.
  - Takes effect immediately, even mid-transfer.
- States: IDLE, OWN0, OWN1. Owner requests are the only ones ever visible to the slave.
- IDLE:
  - Only one cyc high → next state OWN of that master.
  - Both high → OWN of the master ≠ last.
  - last updates on every grant.
  - Grant latency: 1 clock from master cyc to o_s_cyc.
- OWNx datapath (combinational mux):
  - o_s_cyc = i_mx_cyc & ~abort; o_s_stb = i_mx_stb & ~abort; we/adr/dat/sel come from mx.
  - o_mx_ack = i_s_ack; o_mx_err = i_s_err | timeout_pulse.
  - Non-owner sees ack = err = 0. Its stalled request is held, never dropped.
- Release from OWNx (i_mx_cyc low):
  - Other master's cyc high → go directly to OWNy (back-to-back, no idle cycle).
  - Otherwise → IDLE.
  - Pipelined/burst multi-beat transfers stay with one owner while cyc stays high.
- Ack arriving in the same cycle the owner drops cyc is still routed to the owner.
- Watchdog (TIMEOUT > 0):
  - Counter clears on grant, on i_s_ack, on i_s_err, and while owner stb is low.
  - Increments each cycle owner stb is high with no ack/err.
  - When it reaches TIMEOUT: o_mx_err pulses for exactly 1 cycle and abort is set. Abort forces o_s_cyc/stb low until the owner drops cyc; the owner drops cyc → abort clears.
  - i_s_ack and the timeout in the same cycle → ack wins, no err, counter clears.
- i_s_ack/i_s_err in IDLE or during abort are ignored (not forwarded).
- No combinational path from i_mN_cyc to o_grant; o_grant is registered state.

Test Plan:
- Single m0 read, slave acks 2 cycles after stb with data 0xDEADBEEF → o_s_cyc rises 1 clk after i_m0_cyc; o_m0_ack=1 with o_m0_dat=0xDEADBEEF; o_m1_ack stays 0; o_grant=01.
- m0 and m1 assert cyc in the same cycle from reset → m0 granted first; on m0 cyc drop, m1 owns the very next cycle (o_grant 01→10, no 00). Repeat: second tie goes to m1's rival per last, alternating.
- m1 holds cyc for 4 back-to-back acked beats while m0 requests → m0 sees no ack and no slave access until m1 drops cyc; all 4 beats reach the slave with m1 adr/sel.
- TIMEOUT=8, m0 strobes and slave never acks → o_m0_err high exactly in cycle 8 of the stall; o_s_cyc low from then until m0 drops cyc; next m1 request is granted normally.
- Ack coincides with the counter hitting TIMEOUT → ack only, no err. Slave i_s_err=1 → forwarded to owner only.
- i_reset_n pulled low mid-transfer while OWN1 → o_s_cyc/stb, o_grant and acks drop asynchronously to 0. After release, state is IDLE and m0 wins the next tie.
